// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Holds the queue entry bundle and fetch-side constants.
package fetch_pkg;

    localparam int FETCH_PC_W  = 9;
    localparam int FETCH_INS_W = 32;

    localparam logic [FETCH_PC_W-1:0]  DEFAULT_RESET_PC = '0;
    localparam logic [FETCH_INS_W-1:0] NOP_INSTR        = 32'h0000_0013;

    // One fetched instruction and the address it came from.
    typedef struct packed {
        logic [FETCH_PC_W-1:0]  pc;
        logic [FETCH_INS_W-1:0] instr;
    } fetch_entry_t;

    // Sequential successor of a fetch address; wraps modulo 2^PC_W.
    function automatic logic [FETCH_PC_W-1:0] seq_pc(
        input logic [FETCH_PC_W-1:0] pc
    );
        return pc + FETCH_PC_W'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order circular queue of fetch_entry_t between memory and decode.
// Ports: clk, reset, push/din, pop, flush, head (entry at rd pointer), occ.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] occ
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_OCC = CW'(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic empty;
    logic full;
    logic do_pop;
    logic do_push;

    assign empty   = (occ == '0);
    assign full    = (occ == FULL_OCC);
    assign do_pop  = pop && !empty;
    // A full queue can still take a push when the head leaves together.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Upstream credit accounting must never let a push hit a full queue.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (reset || flush)
        !(push && full && !pop)
    );

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: issues sequential PCs to imem, queues responses for decode.
// Ports: imem_* request/response, redirect_* from EX, out_* toward IF/ID.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int PC_W  = FETCH_PC_W,
    parameter int INS_W = FETCH_INS_W,
    parameter int DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [INS_W-1:0] out_instr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   occ;
    logic [CW:0]     in_use;

    logic accept;
    logic rsp;
    logic keep;
    logic pop;
    fetch_entry_t din;
    fetch_entry_t head;

    // Entries held plus requests in flight may never exceed the queue size,
    // so every response that is kept is guaranteed a slot.
    assign in_use    = {1'b0, occ} + {1'b0, outstanding};
    assign imem_req  = !reset && !redirect_valid && (in_use < CREDITS);
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp  = imem_rvalid && (outstanding != '0);
    assign keep = rsp && (drop_cnt == '0) && !redirect_valid;

    assign out_valid = (occ != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign out_pc    = (occ != '0) ? head.pc : '0;
    assign out_instr = (occ != '0) ? head.instr : '0;

    assign din.pc    = resp_pc;
    assign din.instr = imem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight belongs to the wrong path; a
            // response landing this cycle is already counted out.
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            outstanding <= outstanding - CW'(rsp);
            drop_cnt    <= outstanding - CW'(rsp);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + PC_W'(4);
            end
            outstanding <= outstanding + CW'(accept) - CW'(rsp);
            if (rsp) begin
                if (drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end else begin
                    resp_pc <= resp_pc + PC_W'(4);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (keep),
        .din   (din),
        .pop   (pop),
        .flush (redirect_valid),
        .head  (head),
        .occ   (occ)
    );

    a_rvalid_expected : assert property (
        @(posedge clk) disable iff (reset)
        !(imem_rvalid && (outstanding == '0))
    );

endmodule
